// File: rtl/x83_decode_if.sv
// Handshake bundle for the x83 decoder: encoded word in, decoded word out.
// master drives words in and accepts results; slave is the decoder itself.
interface x83_decode_if;
   logic [7:0] data_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] data_out;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   modport master (
      output data_in, in_valid, out_ready,
      input  in_ready, data_out, out_valid, busy
   );

   modport slave (
      input  data_in, in_valid, out_ready,
      output in_ready, data_out, out_valid, busy
   );
endinterface

// File: rtl/x83_decode.sv
// Bit-serial inverse of the x83 mod-256 scrambler: multiplies the received word
// by INV_K (219 = 83^-1 mod 256), one constant bit per clock.
module x83_decode #(
   parameter logic [7:0] INV_K = 8'd219
) (
   input  logic           clk,
   input  logic           rst_n,
   x83_decode_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] operand;
   logic [7:0] acc;
   logic [2:0] bit_idx;
   logic [7:0] addend;

   assign addend = operand << bit_idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid)      next_state = CALC;
         CALC:    if (bit_idx == 3'd7)   next_state = DONE;
         DONE:    if (bus.out_ready)     next_state = IDLE;
         default:                        next_state = IDLE;
      endcase
   end

   // Index wraps back to 0 after step 7, but the FSM has left CALC by then.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         operand <= 8'h00;
         acc     <= 8'h00;
         bit_idx <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  operand <= bus.data_in;
                  acc     <= 8'h00;
                  bit_idx <= 3'd0;
               end
            end
            CALC: begin
               if (INV_K[bit_idx]) begin
                  acc <= acc + addend;
               end
               bit_idx <= bit_idx + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == CALC) || (state == DONE);
   assign bus.data_out  = acc;

endmodule
